// File: rtl/sabitler_pkg.sv
// Shared constants and enums for the divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sabitler_pkg;

    localparam int SOZCUK_GENISLIGI            = 32;
    localparam int BOLME_HER_CEVRIM_BIT_SAYISI = 1;

    typedef enum logic [1:0] {
        ISLEM_DIV  = 2'b00,
        ISLEM_DIVU = 2'b01,
        ISLEM_REM  = 2'b10,
        ISLEM_REMU = 2'b11
    } bolme_islem_t;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        DUZELT  = 2'd2,
        SONUC   = 2'd3
    } bolme_durum_t;

endpackage

// File: rtl/bolme_adimi.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial remainder.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the result is registered.
module bolme_adimi
    import sabitler_pkg::*;
#(
    parameter int VERI_GENISLIGI = SOZCUK_GENISLIGI
)(
    input  logic [VERI_GENISLIGI:0]   i_kalan,
    input  logic [VERI_GENISLIGI-1:0] i_bolum,
    input  logic [VERI_GENISLIGI-1:0] i_bolen,
    output logic [VERI_GENISLIGI:0]   o_kalan,
    output logic [VERI_GENISLIGI-1:0] o_bolum
);

    localparam int GENIS = VERI_GENISLIGI + 2;
    localparam int KALAN_W = VERI_GENISLIGI + 1;

    logic [GENIS-1:0] w_kaydirilmis;
    logic [GENIS-1:0] w_fark;
    logic             w_sigar;

    // Shift in the dividend MSB, subtract the divisor if it fits, record the quotient bit.
    // An extra top bit keeps the comparison safe for any partial remainder value.
    always_comb begin
        w_kaydirilmis = {i_kalan, i_bolum[VERI_GENISLIGI-1]};
        w_fark        = w_kaydirilmis - {2'b00, i_bolen};
        w_sigar       = (w_kaydirilmis >= {2'b00, i_bolen});
        o_kalan       = KALAN_W'(w_sigar ? w_fark : w_kaydirilmis);
        o_bolum       = {i_bolum[VERI_GENISLIGI-2:0], w_sigar};
    end

endmodule

// File: rtl/bolme_birimi.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes on request and result.
// Latency: N+2 cycles (N = width / bits per cycle); divide-by-zero and signed overflow take 1 cycle.
// Backpressure: result holds in SONUC until sonuc_hazir_i; no request is accepted outside BOSTA.
module bolme_birimi
    import sabitler_pkg::*;
#(
    parameter int VERI_GENISLIGI = SOZCUK_GENISLIGI,
    parameter int HER_CEVRIM_BIT = BOLME_HER_CEVRIM_BIT_SAYISI
)(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      istek_gecerli_i,
    output logic                      istek_hazir_o,
    input  logic [1:0]                islem_i,
    input  logic [VERI_GENISLIGI-1:0] bolunen_i,
    input  logic [VERI_GENISLIGI-1:0] bolen_i,
    input  logic                      iptal_i,
    output logic                      sonuc_gecerli_o,
    input  logic                      sonuc_hazir_i,
    output logic [VERI_GENISLIGI-1:0] sonuc_o
);

    localparam int N       = VERI_GENISLIGI / HER_CEVRIM_BIT;
    localparam int SAYAC_W = $clog2(N) + 1;
    localparam logic [SAYAC_W-1:0]        SAYAC_SON  = SAYAC_W'(N - 1);
    localparam logic [SAYAC_W-1:0]        SAYAC_BIR  = SAYAC_W'(1);
    localparam logic [VERI_GENISLIGI-1:0] BIR        = VERI_GENISLIGI'(1);
    localparam logic [VERI_GENISLIGI-1:0] TUM_BIR    = '1;
    localparam logic [VERI_GENISLIGI-1:0] EN_NEGATIF = {1'b1, {(VERI_GENISLIGI-1){1'b0}}};

    if ((VERI_GENISLIGI % HER_CEVRIM_BIT) != 0) begin : g_gecersiz_parametre
        $error("HER_CEVRIM_BIT must divide VERI_GENISLIGI exactly");
    end

    bolme_durum_t                  r_durum;
    bolme_durum_t                  w_sonraki_durum;
    logic [SAYAC_W-1:0]            r_sayac;
    logic [VERI_GENISLIGI:0]       r_kalan;
    logic [VERI_GENISLIGI-1:0]     r_bolum;
    logic [VERI_GENISLIGI-1:0]     r_bolen;
    bolme_islem_t                  r_islem;
    logic                          r_bolunen_isaret;
    logic                          r_bolen_isaret;
    logic                          r_sonuc_gecerli;
    logic [VERI_GENISLIGI-1:0]     r_sonuc;

    bolme_islem_t                  w_islem;
    logic                          w_isaretli;
    logic                          w_bolum_mu;
    logic                          w_sifira_bolme;
    logic                          w_tasma;
    logic [VERI_GENISLIGI-1:0]     w_bolunen_mutlak;
    logic [VERI_GENISLIGI-1:0]     w_bolen_mutlak;
    logic                          w_r_isaretli;
    logic [VERI_GENISLIGI-1:0]     w_bolum_duz;
    logic [VERI_GENISLIGI-1:0]     w_kalan_duz;
    logic [VERI_GENISLIGI-1:0]     w_duz_sonuc;
    logic [HER_CEVRIM_BIT:0][VERI_GENISLIGI:0]   w_kalan_zincir;
    logic [HER_CEVRIM_BIT:0][VERI_GENISLIGI-1:0] w_bolum_zincir;

    assign sonuc_gecerli_o = r_sonuc_gecerli;
    assign sonuc_o         = r_sonuc;

    // Decode the incoming request: signedness, special cases and operand magnitudes.
    always_comb begin
        w_islem          = bolme_islem_t'(islem_i);
        w_isaretli       = (w_islem == ISLEM_DIV) || (w_islem == ISLEM_REM);
        w_bolum_mu       = (w_islem == ISLEM_DIV) || (w_islem == ISLEM_DIVU);
        w_sifira_bolme   = (bolen_i == '0);
        w_tasma          = w_isaretli && (bolunen_i == EN_NEGATIF) && (bolen_i == TUM_BIR);
        w_bolunen_mutlak = (w_isaretli && bolunen_i[VERI_GENISLIGI-1]) ? (~bolunen_i + BIR) : bolunen_i;
        w_bolen_mutlak   = (w_isaretli && bolen_i[VERI_GENISLIGI-1])   ? (~bolen_i + BIR)   : bolen_i;
    end

    // Chain of restoring steps evaluated within one HESAPLA cycle.
    assign w_kalan_zincir[0] = r_kalan;
    assign w_bolum_zincir[0] = r_bolum;
    for (genvar g = 0; g < HER_CEVRIM_BIT; g++) begin : g_adim
        bolme_adimi #(.VERI_GENISLIGI(VERI_GENISLIGI)) u_adim (
            .i_kalan (w_kalan_zincir[g]),
            .i_bolum (w_bolum_zincir[g]),
            .i_bolen (r_bolen),
            .o_kalan (w_kalan_zincir[g+1]),
            .o_bolum (w_bolum_zincir[g+1])
        );
    end

    // Sign correction of the unsigned magnitudes and selection of quotient or remainder.
    always_comb begin
        w_r_isaretli = (r_islem == ISLEM_DIV) || (r_islem == ISLEM_REM);
        w_bolum_duz  = r_bolum;
        w_kalan_duz  = r_kalan[VERI_GENISLIGI-1:0];
        if (w_r_isaretli && (r_bolunen_isaret ^ r_bolen_isaret)) begin
            w_bolum_duz = ~r_bolum + BIR;
        end
        if (w_r_isaretli && r_bolunen_isaret) begin
            w_kalan_duz = ~r_kalan[VERI_GENISLIGI-1:0] + BIR;
        end
        w_duz_sonuc = ((r_islem == ISLEM_DIV) || (r_islem == ISLEM_DIVU)) ? w_bolum_duz : w_kalan_duz;
    end

    // Next-state logic and request ready; flush overrides every transition.
    always_comb begin
        w_sonraki_durum = r_durum;
        istek_hazir_o   = (r_durum == BOSTA) && !rst_i && !iptal_i;
        case (r_durum)
            BOSTA: begin
                if (istek_gecerli_i) begin
                    w_sonraki_durum = (w_sifira_bolme || w_tasma) ? SONUC : HESAPLA;
                end
            end
            HESAPLA: begin
                if (r_sayac == SAYAC_SON) begin
                    w_sonraki_durum = DUZELT;
                end
            end
            DUZELT:  w_sonraki_durum = SONUC;
            SONUC: begin
                if (sonuc_hazir_i) begin
                    w_sonraki_durum = BOSTA;
                end
            end
            default: w_sonraki_durum = BOSTA;
        endcase
        if (iptal_i) begin
            w_sonraki_durum = BOSTA;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_sonraki_durum;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and result hold/clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sayac          <= '0;
            r_kalan          <= '0;
            r_bolum          <= '0;
            r_bolen          <= '0;
            r_islem          <= ISLEM_DIV;
            r_bolunen_isaret <= 1'b0;
            r_bolen_isaret   <= 1'b0;
            r_sonuc_gecerli  <= 1'b0;
            r_sonuc          <= '0;
        end else if (iptal_i) begin
            r_sayac          <= '0;
            r_sonuc_gecerli  <= 1'b0;
            r_sonuc          <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (istek_gecerli_i) begin
                        r_sayac          <= '0;
                        r_kalan          <= '0;
                        r_bolum          <= w_bolunen_mutlak;
                        r_bolen          <= w_bolen_mutlak;
                        r_islem          <= w_islem;
                        r_bolunen_isaret <= bolunen_i[VERI_GENISLIGI-1];
                        r_bolen_isaret   <= bolen_i[VERI_GENISLIGI-1];
                        if (w_sifira_bolme) begin
                            r_sonuc_gecerli <= 1'b1;
                            r_sonuc         <= w_bolum_mu ? TUM_BIR : bolunen_i;
                        end else if (w_tasma) begin
                            r_sonuc_gecerli <= 1'b1;
                            r_sonuc         <= w_bolum_mu ? bolunen_i : '0;
                        end
                    end
                end
                HESAPLA: begin
                    r_kalan <= w_kalan_zincir[HER_CEVRIM_BIT];
                    r_bolum <= w_bolum_zincir[HER_CEVRIM_BIT];
                    r_sayac <= r_sayac + SAYAC_BIR;
                end
                DUZELT: begin
                    r_sonuc_gecerli <= 1'b1;
                    r_sonuc         <= w_duz_sonuc;
                end
                SONUC: begin
                    if (sonuc_hazir_i) begin
                        r_sonuc_gecerli <= 1'b0;
                        r_sonuc         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
